// File: rtl/dct_transpose_buf.sv
// Transpose buffer between the row-pass and column-pass stages of an 8x8 2-D DCT.
// Rows are captured into one bank of a ping-pong pair. The other, completed bank
// is replayed column by column, so the input can stream without stalling.
module dct_transpose_buf #(
  parameter int W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  input  logic signed [W-1:0] d0,
  input  logic signed [W-1:0] d1,
  input  logic signed [W-1:0] d2,
  input  logic signed [W-1:0] d3,
  input  logic signed [W-1:0] d4,
  input  logic signed [W-1:0] d5,
  input  logic signed [W-1:0] d6,
  input  logic signed [W-1:0] d7,
  output logic                out_en,
  output logic signed [W-1:0] q0,
  output logic signed [W-1:0] q1,
  output logic signed [W-1:0] q2,
  output logic signed [W-1:0] q3,
  output logic signed [W-1:0] q4,
  output logic signed [W-1:0] q5,
  output logic signed [W-1:0] q6,
  output logic signed [W-1:0] q7,
  output logic [2:0]          out_col,
  output logic                out_last
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Ping-pong storage, indexed [bank][row][column]
  logic signed [W-1:0] mem [2][8][8];

  logic signed [W-1:0] row_in [8];
  logic signed [W-1:0] q_r [8];

  logic       wr_bank;
  logic       rd_bank;
  logic [2:0] wr_row;
  logic [2:0] rd_col;
  logic [1:0] bank_full;
  logic [1:0] bank_full_nxt;

  logic wr_fire;
  logic wr_done;
  logic next_ready;
  logic load_col;
  logic read_done;

  assign row_in[0] = d0;
  assign row_in[1] = d1;
  assign row_in[2] = d2;
  assign row_in[3] = d3;
  assign row_in[4] = d4;
  assign row_in[5] = d5;
  assign row_in[6] = d6;
  assign row_in[7] = d7;

  assign q0 = q_r[0];
  assign q1 = q_r[1];
  assign q2 = q_r[2];
  assign q3 = q_r[3];
  assign q4 = q_r[4];
  assign q5 = q_r[5];
  assign q6 = q_r[6];
  assign q7 = q_r[7];

  // A flush drops any row presented in the same cycle
  assign wr_fire = in_valid & ~clr;
  assign wr_done = wr_fire & (wr_row == 3'd7);

  // A further block is ready to read if the other bank is already full or is completing now
  assign next_ready = bank_full[~rd_bank] | (wr_done & (wr_bank == ~rd_bank));

  // Storage write: the current row goes into the write bank; contents need no reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int c = 0; c < 8; c++) begin
        mem[wr_bank][wr_row][c] <= row_in[c];
      end
    end
  end

  // Write-side row counter and bank pointer; a completed block flips the write bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_row  <= 3'd0;
      wr_bank <= 1'b0;
    end else if (clr) begin
      wr_row  <= 3'd0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      wr_row <= wr_row + 3'd1;
      if (wr_row == 3'd7) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Bank occupancy: set when a block completes, cleared once its last column is read
  always_comb begin
    bank_full_nxt = bank_full;
    if (read_done) begin
      bank_full_nxt[rd_bank] = 1'b0;
    end
    if (wr_done) begin
      bank_full_nxt[wr_bank] = 1'b1;
    end
  end

  // Read-side FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start on a completed block, keep reading while blocks are queued
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_done || bank_full[rd_bank]) begin
          state_nxt = READ;
        end
      end
      READ: begin
        if (rd_col == 3'd7 && !next_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: load one column per READ cycle, with the block finished at column 7
  always_comb begin
    load_col  = 1'b0;
    read_done = 1'b0;
    if (state == READ) begin
      load_col  = 1'b1;
      read_done = (rd_col == 3'd7);
    end
  end

  // Read column counter, read bank pointer and bank occupancy flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_col    <= 3'd0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
    end else if (clr) begin
      rd_col    <= 3'd0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      bank_full <= bank_full_nxt;
      if (load_col) begin
        rd_col <= rd_col + 3'd1;
      end
      if (read_done) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  // Registered column outputs; data holds while idle or flushed, only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en   <= 1'b0;
      out_col  <= 3'd0;
      out_last <= 1'b0;
      for (int r = 0; r < 8; r++) begin
        q_r[r] <= '0;
      end
    end else if (clr) begin
      out_en   <= 1'b0;
      out_col  <= 3'd0;
      out_last <= 1'b0;
    end else if (load_col) begin
      out_en   <= 1'b1;
      out_col  <= rd_col;
      out_last <= (rd_col == 3'd7);
      for (int r = 0; r < 8; r++) begin
        q_r[r] <= mem[rd_bank][r][rd_col];
      end
    end else begin
      out_en   <= 1'b0;
      out_col  <= 3'd0;
      out_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Self-checking bench for dct_transpose_buf. A scoreboard queue collects the expected columns
// as rows are driven. A negedge monitor pops and compares them whenever out_en is high.
module tb_dct_transpose_buf;

  localparam int W = 10;

  typedef struct packed {
    logic [2:0]          col;
    logic                last;
    logic [7:0][W-1:0]   q;
  } col_t;

  logic clk;
  logic rst_n;
  logic clr;
  logic in_valid;
  logic [7:0][W-1:0] d_bus;
  logic [7:0][W-1:0] q_all;
  logic signed [W-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic out_en;
  logic [2:0] out_col;
  logic out_last;

  col_t sb[$];
  col_t last_exp;
  logic [7:0][W-1:0] rows [8];

  int tests_run;
  int tests_failed;

  assign q_all = {q7, q6, q5, q4, q3, q2, q1, q0};

  dct_transpose_buf #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .d0(d_bus[0]), .d1(d_bus[1]), .d2(d_bus[2]), .d3(d_bus[3]),
    .d4(d_bus[4]), .d5(d_bus[5]), .d6(d_bus[6]), .d7(d_bus[7]),
    .out_en(out_en),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
    .out_col(out_col), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element value: mode 0 is base+8r+c, mode 1 is a -512/+511 checkerboard
  function automatic int elem(input int base, input int mode, input int r, input int c);
    if (mode == 1) return (((r + c) % 2) == 0) ? -512 : 511;
    return base + 8 * r + c;
  endfunction

  // Drive nrows rows (gap idle cycles between rows); a completed block pushes its 8 columns
  task automatic send_block(input int base, input int mode, input int gap, input int nrows);
    for (int r = 0; r < nrows; r++) begin
      @(negedge clk);
      for (int c = 0; c < 8; c++) begin
        int v;
        v = elem(base, mode, r, c);
        d_bus[c]   = v[W-1:0];
        rows[r][c] = v[W-1:0];
      end
      in_valid = 1'b1;
      if (r == 7) begin
        for (int j = 0; j < 8; j++) begin
          col_t e;
          e.col  = j[2:0];
          e.last = (j == 7);
          for (int k = 0; k < 8; k++) e.q[k] = rows[k][j];
          sb.push_back(e);
        end
      end
      if (gap > 0 && r < nrows - 1) begin
        repeat (gap) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
    end
  endtask

  // Scoreboard monitor: every out_en cycle must match the oldest expected column
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_en === 1'b1) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL sb_unexpected: out_en=1 col=%0d, expected no output", out_col);
        end else begin
          col_t e;
          e = sb.pop_front();
          last_exp = e;
          if (q_all !== e.q || out_col !== e.col || out_last !== e.last) begin
            tests_failed++;
            $display("[TB] FAIL sb_column: got col=%0d last=%0b q=%h, expected col=%0d last=%0b q=%h",
                     out_col, out_last, q_all, e.col, e.last, e.q);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; d_bus = '0;
    #12;
    tests_run++;
    if (out_en !== 1'b0 || out_col !== 3'd0 || out_last !== 1'b0 || q_all !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got en=%0b col=%0d last=%0b q=%h, expected all zero",
               out_en, out_col, out_last, q_all);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_block();
    send_block(0, 0, 0, 8);
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (out_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_lat_pre: got out_en=%0b, expected 0", out_en);
    end
    @(negedge clk);
    tests_run++;
    if (out_en !== 1'b1 || out_col !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL single_first: got en=%0b col=%0d, expected en=1 col=0", out_en, out_col);
    end
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      tests_run++;
      if (out_en !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL single_run%0d: got out_en=%0b, expected 1", k, out_en);
      end
    end
    @(negedge clk);
    tests_run++;
    if (out_en !== 1'b0 || out_col !== 3'd0 || out_last !== 1'b0 || sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL single_after: got en=%0b col=%0d last=%0b pending=%0d, expected 0 0 0 0",
               out_en, out_col, out_last, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int highs;
    int rises;
    logic prev;
    highs = 0; rises = 0; prev = 1'b0;
    fork
      begin
        for (int b = 0; b < 3; b++) send_block(64 * b, 0, 0, 8);
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (out_en === 1'b1) highs++;
          if (out_en === 1'b1 && prev === 1'b0) rises++;
          prev = out_en;
        end
      end
    join
    tests_run++;
    if (highs != 24 || rises != 1) begin
      tests_failed++;
      $display("[TB] FAIL stream_continuous: got %0d high cycles in %0d bursts, expected 24 in 1",
               highs, rises);
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL stream_drained: got %0d pending columns, expected 0", sb.size());
    end
  endtask

  task automatic test_gapped();
    send_block(0, 0, 1, 8);
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (out_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL gap_lat_pre: got out_en=%0b, expected 0", out_en);
    end
    @(negedge clk);
    tests_run++;
    if (out_en !== 1'b1 || out_col !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL gap_first: got en=%0b col=%0d, expected en=1 col=0", out_en, out_col);
    end
    for (int k = 0; k < 12 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (sb.size() != 0 || out_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL gap_drained: got pending=%0d en=%0b, expected 0 0", sb.size(), out_en);
    end
  endtask

  task automatic test_sign_extremes();
    send_block(0, 1, 0, 8);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 15 && sb.size() != 0; k++) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL sign_drained: got %0d pending columns, expected 0", sb.size());
    end
  endtask

  task automatic test_clr();
    send_block(0, 0, 0, 5);
    @(negedge clk);
    clr = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      tests_run++;
      if (out_en !== 1'b0 || q_all !== last_exp.q) begin
        tests_failed++;
        $display("[TB] FAIL clr_idle%0d: got en=%0b q=%h, expected en=0 q=%h",
                 k, out_en, q_all, last_exp.q);
      end
    end
    send_block(100, 0, 0, 8);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_en !== 1'b1 || out_col !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL clr_new_first: got en=%0b col=%0d, expected en=1 col=0", out_en, out_col);
    end
    for (int k = 0; k < 12 && sb.size() != 0; k++) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL clr_drained: got %0d pending columns, expected 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_read();
    bit found;
    found = 1'b0;
    send_block(0, 0, 0, 8);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (out_en === 1'b1 && out_col === 3'd3) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("[TB] FAIL rst_reach_col3: got no col 3 within 12 cycles, expected col 3");
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_en !== 1'b0 || out_col !== 3'd0 || out_last !== 1'b0 || q_all !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rst_async: got en=%0b col=%0d last=%0b q=%h, expected all zero",
               out_en, out_col, out_last, q_all);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests_run++;
      if (out_en !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rst_no_more%0d: got out_en=%0b, expected 0", k, out_en);
      end
    end
    send_block(0, 0, 0, 8);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_en !== 1'b1 || out_col !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL rst_next_first: got en=%0b col=%0d, expected en=1 col=0", out_en, out_col);
    end
    for (int k = 0; k < 12 && sb.size() != 0; k++) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL rst_drained: got %0d pending columns, expected 0", sb.size());
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    last_exp = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_block();
    test_back_to_back();
    test_gapped();
    test_sign_extremes();
    test_clr();
    test_reset_mid_read();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
